// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared definitions for the NTT engine blocks:
//   - NTT_Q       : Goldilocks prime 2^64 - 2^32 + 1, the coefficient modulus
//   - NTT_ADDR_W  : default BRAM byte-address width
//   - NTT_DATA_W  : default coefficient width
//   - strm_state_e: control states of the result streamer
// ---------------------------------------------------------------------------
package ntt_pkg;

    localparam logic [63:0] NTT_Q      = 64'hFFFF_FFFF_0000_0001;
    localparam int          NTT_ADDR_W = 13;
    localparam int          NTT_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // waiting for the engine's completion pulse
        ST_STREAM = 2'd1,  // issuing BRAM reads under credit control
        ST_DRAIN  = 2'd2,  // all reads issued, FIFO emptying
        ST_DONE   = 2'd3   // one-cycle completion state
    } strm_state_e;

endpackage

// File: rtl/ntt_result_streamer_if.sv
// ---------------------------------------------------------------------------
// ntt_stream_if
// Valid/ready coefficient stream from the NTT result streamer to the proof
// pipeline.
//   m_valid : word valid (producer)
//   m_ready : consumer ready (consumer)
//   m_data  : coefficient (producer)
//   m_last  : final coefficient of the transform (producer)
// Modports: master (producer side), slave (consumer side).
// ---------------------------------------------------------------------------
interface ntt_stream_if
    import ntt_pkg::*;
#(
    parameter int DATA_W = NTT_DATA_W
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/ntt_stream_fifo.sv
// ---------------------------------------------------------------------------
// ntt_stream_fifo
// Synchronous FIFO used as the streamer's prefetch buffer. Storage is a flop
// array, so the head word is presented straight from registers; a word written
// on one edge is visible at the output from the next cycle on.
// Ports:
//   clk, rst (sync, active-low)
//   flush           : empties the FIFO on the next edge
//   wr_en, wr_data  : push (caller guarantees no overflow)
//   rd_en           : pop the head word when rd_valid
//   rd_valid        : FIFO non-empty
//   rd_data         : head word, forced to 0 while empty
//   count           : current occupancy, used for read credits
// ---------------------------------------------------------------------------
module ntt_stream_fifo
    import ntt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = NTT_DATA_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign rd_valid = (cnt_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = cnt_q;
    assign do_rd    = rd_en && rd_valid;

    always_comb begin
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(do_rd);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries data only; emptiness is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ntt_result_streamer.sv
// ---------------------------------------------------------------------------
// ntt_result_streamer
// On the engine's completion pulse, reads N_WORDS coefficients out of the
// shared NTT BRAM and streams them to the proof pipeline. Reads are
// credit-limited so that in-flight reads plus buffered words never exceed
// FIFO_DEPTH; the prefetch FIFO can therefore never overflow, and
// back-pressure never drops or duplicates a coefficient.
// Ports:
//   clk, rst (sync, active-low), start (one-cycle pulse = ntt_done)
//   BRAM_addr/BRAM_clk/BRAM_din/BRAM_dout/BRAM_en/BRAM_we : read-only BRAM port
//   m (ntt_stream_if.master) : m_valid/m_ready/m_data/m_last stream
//   busy      : transfer in progress
//   done      : one-cycle pulse after the last beat is accepted
//   range_err : sticky "coefficient >= NTT_Q" flag
// Build option: define NTT_STREAMER_RANGE_CHECK_EN to include the range
// comparator; otherwise range_err is tied to 0.
// ---------------------------------------------------------------------------
module ntt_result_streamer
    import ntt_pkg::*;
#(
    parameter int ADDR_W      = NTT_ADDR_W,
    parameter int DATA_W      = NTT_DATA_W,
    parameter int N_WORDS     = 1024,
    parameter int ADDR_STRIDE = 8,
    parameter int READ_LAT    = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] BRAM_addr,
    output logic              BRAM_clk,
    output logic [DATA_W-1:0] BRAM_din,
    input  logic [DATA_W-1:0] BRAM_dout,
    output logic              BRAM_en,
    output logic              BRAM_we,
    ntt_stream_if.master      m,
    output logic              busy,
    output logic              done,
    output logic              range_err
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    strm_state_e         state_q, state_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_q, en_d;
    logic [READ_LAT-1:0] pipe_q, pipe_d;
    logic [IDX_W-1:0]    beat_q, beat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                start_ok;
    logic                fifo_wr;
    logic                fifo_rd;
    logic                fifo_valid;
    logic [DATA_W-1:0]   fifo_data;
    logic [CNT_W-1:0]    fifo_cnt;
    int                  inflight_nxt;
    int                  occ_nxt;
    logic                credit_ok;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
        return ADDR_W'(int'(idx) * ADDR_STRIDE);
    endfunction

    assign BRAM_clk  = clk;
    assign BRAM_din  = '0;
    assign BRAM_we   = 1'b0;
    assign BRAM_en   = en_q;
    assign BRAM_addr = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign start_ok = (state_q == ST_IDLE) && start;
    // pipe_q tracks issued reads; its tail marks the cycle BRAM_dout is valid.
    assign fifo_wr  = pipe_q[READ_LAT-1];
    assign fifo_rd  = fifo_valid && m.m_ready;

    assign m.m_valid = fifo_valid;
    assign m.m_data  = fifo_data;
    assign m.m_last  = fifo_valid && (beat_q == LAST_IDX);

    ntt_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (start_ok),
        .wr_en    (fifo_wr),
        .wr_data  (BRAM_dout),
        .rd_en    (fifo_rd),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_data),
        .count    (fifo_cnt)
    );

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        addr_d   = addr_q;
        en_d     = 1'b0;
        beat_d   = beat_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        pipe_d[0] = en_q;
        for (int k = 1; k < READ_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end

        // Credits for the next cycle: reads still outstanding after this edge
        // (the current one plus all not yet landing) plus post-edge occupancy.
        inflight_nxt = int'(en_q);
        for (int k = 0; k < READ_LAT - 1; k++) begin
            inflight_nxt = inflight_nxt + int'(pipe_q[k]);
        end
        occ_nxt   = int'(fifo_cnt) + int'(fifo_wr) - int'(fifo_rd);
        credit_ok = (inflight_nxt + occ_nxt) < FIFO_DEPTH;

        if (fifo_rd && (beat_q != LAST_IDX)) begin
            beat_d = beat_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_STREAM;
                    rd_idx_d = '0;
                    addr_d   = '0;
                    en_d     = 1'b1;
                    beat_d   = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_STREAM: begin
                if (en_q && (rd_idx_q == LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end else begin
                    if (en_q) begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                    addr_d = addr_of(rd_idx_d);
                    en_d   = credit_ok;
                end
            end
            ST_DRAIN: begin
                en_d = 1'b0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (((state_q == ST_STREAM) || (state_q == ST_DRAIN)) &&
            fifo_rd && (beat_q == LAST_IDX)) begin
            state_d = ST_DONE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    // Control/output registers; reset also discards in-flight read markers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rd_idx_q <= '0;
            addr_q   <= '0;
            en_q     <= 1'b0;
            pipe_q   <= '0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            pipe_q   <= pipe_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef NTT_STREAMER_RANGE_CHECK_EN
    localparam int CMP_W = (DATA_W > 64) ? DATA_W : 64;

    logic range_err_q, range_err_d;

    function automatic logic over_q(input logic [DATA_W-1:0] v);
        logic [CMP_W-1:0] ve;
        ve = CMP_W'(v);
        return ve >= CMP_W'(NTT_Q);
    endfunction

    // Checked on FIFO entry; data is forwarded unchanged either way.
    always_comb begin
        range_err_d = range_err_q;
        if (start_ok) begin
            range_err_d = 1'b0;
        end else if (fifo_wr && over_q(BRAM_dout)) begin
            range_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_result_streamer.sv
module tb_ntt_result_streamer;
    import ntt_pkg::*;

    localparam int N     = 1024;
    localparam int DEPTH = 4;
    localparam int RL    = 1;
    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int N2    = 16;
    localparam int RL2   = 2;

`ifdef NTT_STREAMER_RANGE_CHECK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start2;
    logic [AW-1:0] addr1, addr2;
    logic          bclk1, bclk2;
    logic [DW-1:0] din1, din2, dout1, dout2;
    logic          en1, en2, we1, we2;
    logic          busy1, busy2, done1, done2, rerr1, rerr2;

    ntt_stream_if #(.DATA_W(DW)) s1 ();
    ntt_stream_if #(.DATA_W(DW)) s2 ();

    ntt_result_streamer #(
        .ADDR_W(AW), .DATA_W(DW), .N_WORDS(N), .ADDR_STRIDE(8),
        .READ_LAT(RL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .BRAM_addr(addr1), .BRAM_clk(bclk1), .BRAM_din(din1), .BRAM_dout(dout1),
        .BRAM_en(en1), .BRAM_we(we1), .m(s1),
        .busy(busy1), .done(done1), .range_err(rerr1)
    );

    ntt_result_streamer #(
        .ADDR_W(AW), .DATA_W(DW), .N_WORDS(N2), .ADDR_STRIDE(8),
        .READ_LAT(RL2), .FIFO_DEPTH(DEPTH)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .BRAM_addr(addr2), .BRAM_clk(bclk2), .BRAM_din(din2), .BRAM_dout(dout2),
        .BRAM_en(en2), .BRAM_we(we2), .m(s2),
        .busy(busy2), .done(done2), .range_err(rerr2)
    );

    // Behavioural BRAMs: latency 1 for dut, latency 2 for dut2.
    logic [63:0] mem1 [N];
    always @(posedge clk) if (en1) dout1 <= mem1[addr1[12:3]];

    function automatic logic [63:0] w2(input int i);
        return 64'(i * 3 + 5);
    endfunction
    logic [63:0] d2a;
    always @(posedge clk) begin
        if (en2) d2a <= w2(int'(addr2[12:3]));
        dout2 <= d2a;
    end

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        rknown;
        logic        rval;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int failures = 0;
    int issued = 0;
    int accepted = 0;
    bit exp_done = 0;
    bit prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_last;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Expected stream from the memory image. range_err at a beat is known to
    // be 1 once an offending word is at or before it, and known to be 0 if no
    // offending word could have entered the FIFO yet (at most DEPTH-1 ahead).
    task automatic push_expected();
        bit bad [N];
        exp_t e;
        for (int j = 0; j < N; j++) begin
            bad[j] = ((j > 0) ? bad[j-1] : 1'b0) | (mem1[j] >= NTT_Q);
        end
        for (int j = 0; j < N; j++) begin
            int hi;
            hi = (j + DEPTH - 1 < N) ? j + DEPTH - 1 : N - 1;
            e.data = mem1[j];
            e.last = (j == N - 1);
            if (bad[j]) begin
                e.rknown = 1'b1; e.rval = RCHK;
            end else if (!bad[hi]) begin
                e.rknown = 1'b1; e.rval = 1'b0;
            end else begin
                e.rknown = 1'b0; e.rval = 1'b0;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each accepted beat; also checks stall
    // stability, read addresses, credit limit and the done pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                issued = 0; accepted = 0; exp_done = 0; prev_stall = 0;
            end else begin
                if (prev_stall)
                    chk(s1.m_valid && s1.m_data == prev_data && s1.m_last == prev_last,
                        "stall_hold", s1.m_data, prev_data);
                if (exp_done) begin
                    chk(done1 && !busy1, "done_pulse", {done1, busy1}, 2'b10);
                    exp_done = 0; issued = 0; accepted = 0;
                end else begin
                    chk(done1 == 1'b0, "done_spurious", done1, 0);
                end
                if (en1) begin
                    chk(addr1 == AW'(issued * 8), "bram_addr", addr1, issued * 8);
                    chk(issued + 1 - accepted <= DEPTH, "credit", issued + 1 - accepted, DEPTH);
                    issued++;
                end
                if (s1.m_valid && s1.m_ready) begin
                    chk(sbq.size() != 0, "beat_expected", sbq.size(), 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk(s1.m_data == e.data, "beat_data", s1.m_data, e.data);
                        chk(s1.m_last == e.last, "beat_last", s1.m_last, e.last);
                        if (e.rknown) chk(rerr1 == e.rval, "range_err", rerr1, e.rval);
                    end
                    accepted++;
                    if (s1.m_last) exp_done = 1;
                end
                prev_stall = s1.m_valid && !s1.m_ready;
                prev_data  = s1.m_data;
                prev_last  = s1.m_last;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk(s1.m_valid == 0 && s1.m_last == 0, {tag, "_mvalid_mlast"}, {s1.m_valid, s1.m_last}, 0);
        chk(s1.m_data == 0, {tag, "_mdata"}, s1.m_data, 0);
        chk(busy1 == 0 && done1 == 0, {tag, "_busy_done"}, {busy1, done1}, 0);
        chk(en1 == 0 && addr1 == 0, {tag, "_bram_en_addr"}, {en1, addr1}, 0);
        chk(we1 == 0 && din1 == 0, {tag, "_bram_we_din"}, {we1, din1}, 0);
        chk(rerr1 == 0, {tag, "_range_err"}, rerr1, 0);
        chk(bclk1 == clk, {tag, "_bram_clk"}, bclk1, clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done1) begin seen = 1; break; end
        end
        chk(seen, {tag, "_timeout"}, seen, 1);
    endtask

    initial begin : main
        int first, lastk, donek, beat2, first2, donek2;
        bit pulsed, reached;
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        s1.m_ready = 1'b0; s2.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_values("rst0");
        chk(s2.m_valid == 0 && busy2 == 0 && en2 == 0 && rerr2 == 0 && we2 == 0 && din2 == 0 && bclk2 == clk,
            "rst0_dut2", {s2.m_valid, busy2, en2}, 0);

        // T1: word i = i, ready held high, latency and done timing.
        for (int i = 0; i < N; i++) mem1[i] = 64'(i);
        s1.m_ready = 1'b1;
        push_expected();
        start_pulse();
        first = -1; lastk = -1; donek = -1;
        for (int k = 1; k <= N + 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk(busy1 == 1, "t1_busy_rise", busy1, 1);
                chk(en1 == 1, "t1_first_en", en1, 1);
            end
            if (s1.m_valid && first < 0) first = k;
            if (s1.m_valid && s1.m_last) lastk = k;
            if (done1) begin donek = k; break; end
        end
        chk(first == RL + 2, "t1_first_valid", first, RL + 2);
        chk(lastk == RL + 1 + N, "t1_last_beat", lastk, RL + 1 + N);
        chk(donek == RL + 2 + N, "t1_done_time", donek, RL + 2 + N);
        @(negedge clk);
        chk(busy1 == 0 && done1 == 0, "t1_after_done", {busy1, done1}, 0);
        chk(sbq.size() == 0, "t1_drained", sbq.size(), 0);

        // T2: random data, random ready, extra start mid-stream is ignored.
        for (int i = 0; i < N; i++) mem1[i] = {$urandom, $urandom};
        push_expected();
        start_pulse();
        pulsed = 0; reached = 0;
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done1) begin reached = 1; break; end
            s1.m_ready = 1'($urandom_range(0, 1));
            if (!pulsed && accepted >= 100) begin start = 1'b1; pulsed = 1; end
        end
        chk(reached, "t2_timeout", reached, 1);
        @(negedge clk);
        chk(sbq.size() == 0, "t2_drained", sbq.size(), 0);
        repeat (3) @(negedge clk);
        chk(busy1 == 0 && s1.m_valid == 0, "t2_no_restart", {busy1, s1.m_valid}, 0);

        // T3: reset around beat 500, then a clean restart from address 0.
        for (int i = 0; i < N; i++) mem1[i] = 64'(i);
        push_expected();
        start_pulse();
        reached = 0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #1;
            s1.m_ready = 1'($urandom_range(0, 1));
            if (accepted >= 500) begin reached = 1; break; end
        end
        chk(reached, "t3_reach500", reached, 1);
        rst = 1'b0;
        sbq.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_reset_values("t3_midrst");

        // T4: restart after reset; word 7 out of range.
        for (int i = 0; i < N; i++) mem1[i] = 64'(i);
        mem1[7] = 64'hFFFF_FFFF_FFFF_FFFF;
        s1.m_ready = 1'b1;
        push_expected();
        start_pulse();
        wait_done("t4", N + 50);
        chk(rerr1 == RCHK, "t4_range_sticky", rerr1, RCHK);
        @(negedge clk);
        chk(sbq.size() == 0, "t4_drained", sbq.size(), 0);

        // T5: READ_LAT=2 instance, ready held high.
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        beat2 = 0; first2 = -1; donek2 = -1;
        for (int k = 1; k <= N2 + 20; k++) begin
            @(negedge clk);
            if (s2.m_valid) begin
                if (first2 < 0) first2 = k;
                chk(s2.m_data == w2(beat2), "t5_data", s2.m_data, w2(beat2));
                chk(s2.m_last == (beat2 == N2 - 1), "t5_last", s2.m_last, beat2 == N2 - 1);
                beat2++;
            end
            if (done2) begin donek2 = k; break; end
        end
        chk(first2 == RL2 + 2, "t5_first_valid", first2, RL2 + 2);
        chk(beat2 == N2, "t5_beat_count", beat2, N2);
        chk(donek2 == RL2 + 2 + N2, "t5_done_time", donek2, RL2 + 2 + N2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
